// File: rtl/hex_gpu_pkg.sv
// Shared types for the hex GPU event back end.
// Event layout, FSM states and the lane priority encoder.
package hex_gpu_pkg;

   localparam int EVT_W   = 64;
   localparam int Q_W     = 16;
   localparam int R_W     = 16;
   localparam int DEPTH_W = 8;
   localparam int MAT_W   = 8;

   typedef struct packed {
      logic [Q_W-1:0]     q;
      logic [R_W-1:0]     r;
      logic [DEPTH_W-1:0] depth;
      logic [MAT_W-1:0]   material;
      logic [7:0]         frame;
      logic [7:0]         lane;
   } hex_event_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCEPT,
      S_SERIAL
   } fsm_state_t;

   function automatic logic [4:0] lowest_set(input logic [31:0] mask);
      logic [4:0] idx;
      idx = '0;
      for (int i = 31; i >= 0; i--) begin
         if (mask[i]) idx = 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/hex_event_bank_ram.sv
// Two-bank event store: one write port, one registered read port.
// Bank select is the top address bit so the array maps onto one block RAM.
module hex_event_bank_ram
   import hex_gpu_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic             wr_bank,
   input  logic [AW-1:0]    wr_addr,
   input  logic [EVT_W-1:0] wr_data,
   input  logic             rd_bank,
   input  logic [AW-1:0]    rd_addr,
   output logic [EVT_W-1:0] rd_data
);

   logic [EVT_W-1:0] mem [2*DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[{wr_bank, wr_addr}] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) rd_data <= '0;
      else       rd_data <= mem[{rd_bank, rd_addr}];
   end

endmodule

// File: rtl/hex_event_packer_db.sv
// Serializes masked hex batches into packed events in a double-buffered
// event memory; the completed frame is readable while the next is written.
module hex_event_packer_db
   import hex_gpu_pkg::*;
#(
   parameter int BATCH = 10,
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            frame_start,
   input  logic                            frame_end,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [BATCH-1:0]                in_mask,
   input  logic [BATCH-1:0][Q_W-1:0]       q,
   input  logic [BATCH-1:0][R_W-1:0]       r,
   input  logic [BATCH-1:0][DEPTH_W-1:0]   depth_val,
   input  logic [BATCH-1:0][MAT_W-1:0]     material,
   output logic                            busy,
   output logic                            frame_done,
   output logic [AW:0]                     done_count,
   output logic                            done_overflow,
   output logic [15:0]                     drop_count,
   output logic [7:0]                      frame_id,
   input  logic [AW-1:0]                   rd_addr,
   output logic [EVT_W-1:0]                rd_data
);

   localparam int LW = (BATCH > 1) ? $clog2(BATCH) : 1;

   fsm_state_t                    state;
   logic                          wr_bank;
   logic [AW:0]                   wr_count;
   logic                          ovf;
   logic [15:0]                   drops;
   logic                          pend;
   logic [BATCH-1:0]              mask_reg;
   logic [BATCH-1:0][Q_W-1:0]     q_reg;
   logic [BATCH-1:0][R_W-1:0]     r_reg;
   logic [BATCH-1:0][DEPTH_W-1:0] d_reg;
   logic [BATCH-1:0][MAT_W-1:0]   m_reg;

   logic [31:0]   mask32;
   logic [4:0]    idx;
   logic [LW-1:0] lane;
   logic          last;
   logic          room;
   hex_event_t    evt;

   always_comb begin
      mask32               = '0;
      mask32[BATCH-1:0]    = mask_reg;
      idx                  = lowest_set(mask32);
      lane                 = idx[LW-1:0];
      last                 = (mask32 & (mask32 - 32'd1)) == '0;
      room                 = wr_count < (AW+1)'(DEPTH);
      evt.q                = q_reg[lane];
      evt.r                = r_reg[lane];
      evt.depth            = d_reg[lane];
      evt.material         = m_reg[lane];
      evt.frame            = frame_id + 8'd1;
      evt.lane             = 8'(idx);
   end

   // Lane payload only needs capturing; it is always reloaded before use.
   always_ff @(posedge clk) begin
      if (state == S_ACCEPT && in_valid) begin
         q_reg <= q;
         r_reg <= r;
         d_reg <= depth_val;
         m_reg <= material;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         wr_bank       <= 1'b0;
         wr_count      <= '0;
         ovf           <= 1'b0;
         drops         <= '0;
         pend          <= 1'b0;
         mask_reg      <= '0;
         in_ready      <= 1'b0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         done_count    <= '0;
         done_overflow <= 1'b0;
         drop_count    <= '0;
         frame_id      <= '0;
      end else begin
         frame_done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (frame_start) begin
                  state    <= S_ACCEPT;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  wr_count <= '0;
                  ovf      <= 1'b0;
                  drops    <= '0;
                  pend     <= 1'b0;
               end
            end
            S_ACCEPT: begin
               if (in_valid) begin
                  mask_reg <= in_mask;
                  if (frame_end) pend <= 1'b1;
                  if (|in_mask) begin
                     state    <= S_SERIAL;
                     in_ready <= 1'b0;
                  end
               end else if (frame_end || pend) begin
                  state         <= S_IDLE;
                  in_ready      <= 1'b0;
                  busy          <= 1'b0;
                  pend          <= 1'b0;
                  wr_bank       <= ~wr_bank;
                  frame_done    <= 1'b1;
                  done_count    <= wr_count;
                  done_overflow <= ovf;
                  drop_count    <= drops;
                  frame_id      <= frame_id + 8'd1;
               end
            end
            S_SERIAL: begin
               mask_reg[lane] <= 1'b0;
               if (room) begin
                  wr_count <= wr_count + 1'b1;
               end else begin
                  ovf <= 1'b1;
                  if (drops != 16'hFFFF) drops <= drops + 16'd1;
               end
               if (frame_end) pend <= 1'b1;
               if (last) begin
                  state    <= S_ACCEPT;
                  in_ready <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   hex_event_bank_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .we      (state == S_SERIAL && room && !reset),
      .wr_bank (wr_bank),
      .wr_addr (wr_count[AW-1:0]),
      .wr_data (evt),
      .rd_bank (~wr_bank),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule
